video_pal_out: RTL and testbench



---
 rtl/video_pal_out.sv | 144 ++++++++++++++
 tb/tb_video_pal_out.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_pal_out.sv
`default_nettype none
// video_pal_out: VGA scan-out from line buffer through palette to registered pins.
// Optional feature macro VIDEO_PAL_SCANLINE_EN adds scanline_en (halves odd lines).
module video_pal_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       reset_n,
`ifdef VIDEO_PAL_SCANLINE_EN
  input  logic       scanline_en,
`endif
  output logic [9:0] lb_rdaddr,
  output logic [8:0] lb_line,
  input  logic [5:0] lb_rddata,
  output logic [5:0] palidx,
  input  logic [3:0] pal_r,
  input  logic [3:0] pal_g,
  input  logic [3:0] pal_b,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       vblank_irq,
  output logic       line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       SYNC_ACT = (SYNC_POL != 0);

  // Per-pixel flags that travel down the pipeline alongside the colour.
  localparam int F_ACT = 0;
  localparam int F_HS  = 1;
  localparam int F_VS  = 2;
  localparam int F_VBL = 3;
`ifdef VIDEO_PAL_SCANLINE_EN
  localparam int F_ODD = 4;
  localparam int NF    = 5;
`else
  localparam int NF    = 4;
`endif

  logic [9:0]    hcnt_q, hcnt_d;
  logic [9:0]    vcnt_q, vcnt_d;
  logic [NF-1:0] st1_q, st1_d;
  logic [NF-1:0] st2_q, st2_d;
  logic [5:0]    palidx_q, palidx_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          irq_q, irq_d;
  logic          line_start_q, line_start_d;

  always_comb begin
    hcnt_d = (hcnt_q == H_LAST) ? 10'd0 : hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
    end
    line_start_d = (hcnt_q == H_LAST) && (vcnt_d < V_ACT);

    st1_d        = '0;
    st1_d[F_ACT] = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    st1_d[F_HS]  = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
    st1_d[F_VS]  = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
    st1_d[F_VBL] = (hcnt_q == 10'd0) && (vcnt_q == V_ACT);
`ifdef VIDEO_PAL_SCANLINE_EN
    st1_d[F_ODD] = vcnt_q[0];
`endif

    st2_d    = st1_q;
    palidx_d = st1_q[F_ACT] ? lb_rddata : 6'd0;

    rgb_d = 12'h000;
    if (st2_q[F_ACT]) begin
      rgb_d = {pal_r, pal_g, pal_b};
`ifdef VIDEO_PAL_SCANLINE_EN
      if (scanline_en && st2_q[F_ODD]) begin
        rgb_d = {1'b0, pal_r[3:1], 1'b0, pal_g[3:1], 1'b0, pal_b[3:1]};
      end
`endif
    end
    hsync_d = st2_q[F_HS] ? SYNC_ACT : ~SYNC_ACT;
    vsync_d = st2_q[F_VS] ? SYNC_ACT : ~SYNC_ACT;
    irq_d   = st2_q[F_VBL];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q       <= 10'd0;
      vcnt_q       <= 10'd0;
      st1_q        <= '0;
      st2_q        <= '0;
      palidx_q     <= 6'd0;
      rgb_q        <= 12'h000;
      hsync_q      <= ~SYNC_ACT;
      vsync_q      <= ~SYNC_ACT;
      irq_q        <= 1'b0;
      line_start_q <= 1'b0;
    end else begin
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      st1_q        <= st1_d;
      st2_q        <= st2_d;
      palidx_q     <= palidx_d;
      rgb_q        <= rgb_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      irq_q        <= irq_d;
      line_start_q <= line_start_d;
    end
  end

  assign lb_rdaddr  = hcnt_q;
  assign lb_line    = vcnt_q[8:0];
  assign palidx     = palidx_q;
  assign vga_r      = rgb_q[11:8];
  assign vga_g      = rgb_q[7:4];
  assign vga_b      = rgb_q[3:0];
  assign vga_hsync  = hsync_q;
  assign vga_vsync  = vsync_q;
  assign vblank_irq = irq_q;
  assign line_start = line_start_q;

endmodule
`default_nettype wire

// File: tb/tb_video_pal_out.sv
`default_nettype none
// tb_video_pal_out: directed checks of scan-out timing, pixel path and reset on a
// reduced raster (32 clk x 19 lines) so whole frames run quickly.
module tb_video_pal_out;

  localparam int HA = 16, HF = 4, HS = 8, HB = 4;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int F  = 608;  // (16+4+8+4) * (12+2+2+3)

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scanline_en = 1'b0;
  logic [9:0] lb_rdaddr;
  logic [8:0] lb_line;
  logic [5:0] lb_rddata = 6'd0;
  logic [5:0] palidx;
  logic [3:0] pal_r, pal_g, pal_b;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hsync, vga_vsync, vblank_irq, line_start;

  logic       lb_force = 1'b0;
  logic       pal_hot = 1'b0;
  int         cyc;
  int         total = 0;
  int         bad = 0;

  video_pal_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
`ifdef VIDEO_PAL_SCANLINE_EN
    .scanline_en(scanline_en),
`endif
    .lb_rdaddr(lb_rdaddr),
    .lb_line(lb_line),
    .lb_rddata(lb_rddata),
    .palidx(palidx),
    .pal_r(pal_r),
    .pal_g(pal_g),
    .pal_b(pal_b),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync),
    .vblank_irq(vblank_irq),
    .line_start(line_start)
  );

  always #5 clk = ~clk;

  // Edges since reset release: after edge n the counters sit at position n.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always @(posedge clk) lb_rddata <= lb_force ? 6'd7 : lb_rdaddr[5:0];

  always_comb begin
    pal_r = palidx[3:0];
    pal_g = ~palidx[3:0];
    pal_b = 4'h5;
    if (pal_hot && palidx == 6'd7) {pal_r, pal_g, pal_b} = 12'h123;
  end

  wire [11:0] rgb = {vga_r, vga_g, vga_b};

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (rgb !== 12'h000 || palidx !== 6'd0) begin
      bad++; $display("FAIL reset_colour: got rgb=%h idx=%h want 000/00", rgb, palidx);
    end
    total++;
    if (vga_hsync !== 1'b1 || vga_vsync !== 1'b1) begin
      bad++; $display("FAIL reset_sync: got hs=%b vs=%b want 1/1", vga_hsync, vga_vsync);
    end
    total++;
    if (vblank_irq !== 1'b0 || line_start !== 1'b0 || lb_rdaddr !== 10'd0 || lb_line !== 9'd0) begin
      bad++; $display("FAIL reset_misc: got irq=%b ls=%b addr=%0d line=%0d want 0", vblank_irq,
                      line_start, lb_rdaddr, lb_line);
    end
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (lb_rdaddr !== 10'd1) begin
      bad++; $display("FAIL first_edge_addr: got %0d want 1", lb_rdaddr);
    end
  endtask

  task automatic test_pixel;
    wait_cyc(2);
    total++;
    if (rgb !== 12'h000) begin bad++; $display("FAIL pipe_fill: got %h want 000", rgb); end
    wait_cyc(3);
    total++;
    if (rgb !== 12'h0F5) begin bad++; $display("FAIL pixel0: got %h want 0f5", rgb); end
    wait_cyc(10);
    total++;
    if (lb_rdaddr !== 10'd10) begin bad++; $display("FAIL addr10: got %0d want 10", lb_rdaddr); end
    wait_cyc(12);
    total++;
    if (palidx !== 6'd10) begin bad++; $display("FAIL palidx10: got %0d want 10", palidx); end
    wait_cyc(13);
    total++;
    if (rgb !== 12'hA55) begin bad++; $display("FAIL pixel10: got %h want a55", rgb); end
    wait_cyc(18);
    total++;
    if (rgb !== 12'hF05) begin bad++; $display("FAIL last_active: got %h want f05", rgb); end
    wait_cyc(19);
    total++;
    if (rgb !== 12'h000) begin bad++; $display("FAIL first_blank: got %h want 000", rgb); end
  endtask

  task automatic test_hsync;
    wait_cyc(22);
    total++;
    if (vga_hsync !== 1'b1) begin bad++; $display("FAIL hs_before: got %b want 1", vga_hsync); end
    wait_cyc(23);
    total++;
    if (vga_hsync !== 1'b0) begin bad++; $display("FAIL hs_start: got %b want 0", vga_hsync); end
    wait_cyc(30);
    total++;
    if (vga_hsync !== 1'b0) begin bad++; $display("FAIL hs_last: got %b want 0", vga_hsync); end
    wait_cyc(31);
    total++;
    if (vga_hsync !== 1'b1) begin bad++; $display("FAIL hs_end: got %b want 1", vga_hsync); end
  endtask

  task automatic test_frame;
    int ls_cnt = 0, irq_cnt = 0, vs_cnt = 0, irq_at = -1;
    wait_cyc(F - 1);
    total++;
    if (lb_rdaddr !== 10'd31 || lb_line !== 9'd18) begin
      bad++; $display("FAIL frame_end_pos: got %0d/%0d want 31/18", lb_rdaddr, lb_line);
    end
    for (int n = F; n < 2 * F + 3; n++) begin
      wait_cyc(n);
      if (n == F) begin
        total++;
        if (lb_rdaddr !== 10'd0 || lb_line !== 9'd0) begin
          bad++; $display("FAIL frame_wrap_pos: got %0d/%0d want 0/0", lb_rdaddr, lb_line);
        end
      end
      if (n < 2 * F && line_start === 1'b1) ls_cnt++;
      if (n >= F + 3) begin
        if (vblank_irq === 1'b1) begin irq_cnt++; irq_at = n; end
        if (vga_vsync === 1'b0) vs_cnt++;
      end
    end
    total++;
    if (ls_cnt != VA) begin bad++; $display("FAIL line_start_cnt: got %0d want %0d", ls_cnt, VA); end
    total++;
    if (irq_cnt != 1) begin bad++; $display("FAIL irq_cnt: got %0d want 1", irq_cnt); end
    total++;
    if (irq_at != F + 387) begin bad++; $display("FAIL irq_time: got %0d want %0d", irq_at, F + 387); end
    total++;
    if (vs_cnt != 64) begin bad++; $display("FAIL vsync_len: got %0d want 64", vs_cnt); end
  endtask

  task automatic test_palette_change;
    int n0 = 2 * F + 2 * 32 + 2;
    wait_cyc(n0);
    lb_force = 1'b1;
    wait_cyc(n0 + 4);
    total++;
    if (rgb !== 12'h785) begin bad++; $display("FAIL pal_before: got %h want 785", rgb); end
    pal_hot = 1'b1;
    wait_cyc(n0 + 5);
    total++;
    if (rgb !== 12'h123) begin bad++; $display("FAIL pal_after: got %h want 123", rgb); end
    wait_cyc(n0 + 6);
    total++;
    if (rgb !== 12'h123) begin bad++; $display("FAIL pal_next: got %h want 123", rgb); end
    lb_force = 1'b0;
    pal_hot  = 1'b0;
  endtask

`ifdef VIDEO_PAL_SCANLINE_EN
  task automatic test_scanline;
    wait_cyc(18);
    total++;
    if (rgb !== 12'hF05) begin bad++; $display("FAIL scan_even: got %h want f05", rgb); end
    wait_cyc(50);
    total++;
    if (rgb !== 12'h702) begin bad++; $display("FAIL scan_odd: got %h want 702", rgb); end
    scanline_en = 1'b0;
    wait_cyc(114);
    total++;
    if (rgb !== 12'hF05) begin bad++; $display("FAIL scan_off: got %h want f05", rgb); end
  endtask
`endif

  task automatic test_reset_mid;
    wait_cyc(3 * F + 7 * 32 + 9);
    total++;
    if (rgb !== 12'h695) begin bad++; $display("FAIL mid_pixel: got %h want 695", rgb); end
    #1 reset_n = 1'b0;
    #1;
    total++;
    if (rgb !== 12'h000 || vga_hsync !== 1'b1 || vga_vsync !== 1'b1 || palidx !== 6'd0 ||
        lb_rdaddr !== 10'd0) begin
      bad++; $display("FAIL async_reset: got rgb=%h hs=%b vs=%b idx=%0d addr=%0d want 000/1/1/0/0",
                      rgb, vga_hsync, vga_vsync, palidx, lb_rdaddr);
    end
    repeat (3) @(negedge clk);
    scanline_en = 1'b1;
    reset_n = 1'b1;
`ifdef VIDEO_PAL_SCANLINE_EN
    test_scanline();
`endif
    wait_cyc(386);
    total++;
    if (vblank_irq !== 1'b0) begin bad++; $display("FAIL irq_early: got %b want 0", vblank_irq); end
    wait_cyc(387);
    total++;
    if (vblank_irq !== 1'b1) begin bad++; $display("FAIL irq_pulse: got %b want 1", vblank_irq); end
    wait_cyc(388);
    total++;
    if (vblank_irq !== 1'b0) begin bad++; $display("FAIL irq_width: got %b want 0", vblank_irq); end
    wait_cyc(450);
    total++;
    if (vga_vsync !== 1'b1) begin bad++; $display("FAIL vs_before: got %b want 1", vga_vsync); end
    wait_cyc(451);
    total++;
    if (vga_vsync !== 1'b0) begin bad++; $display("FAIL vs_start: got %b want 0", vga_vsync); end
  endtask

  initial begin
    test_reset();
    test_pixel();
    test_hsync();
    test_frame();
    test_palette_change();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
